// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU among N_REQ requesters.
// Operands and results are registered so ALU timing stays isolated from the requesters.
module alu_arbiter #(
  parameter int N_REQ = 2,
  parameter int OP_W  = 3,
  parameter int DW    = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_op,
  input  logic [N_REQ*DW-1:0]   req_a,
  input  logic [N_REQ*DW-1:0]   req_b,
  output logic [OP_W-1:0]       alu_op,
  output logic [DW-1:0]         alu_a,
  output logic [DW-1:0]         alu_b,
  input  logic [DW-1:0]         alu_result,
  input  logic                  alu_overflow,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DW-1:0]         rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_zero,
  output logic                  busy,
  output logic [CNT_W-1:0]      ovf_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            grant_valid;
  int              idx;

  // Scan from the farthest position back to rr_ptr so the closest valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = ID_W'(idx);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && (state == IDLE) && grant_valid && (grant == ID_W'(gi));
    end
  endgenerate

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      ovf_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            alu_op <= req_op[grant*OP_W +: OP_W];
            alu_a  <= req_a[grant*DW +: DW];
            alu_b  <= req_b[grant*DW +: DW];
            rsp_id <= grant;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_overflow <= alu_overflow;
          rsp_zero     <= alu_zero;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
            if (rsp_overflow && (ovf_cnt != '1)) begin
              ovf_cnt <= ovf_cnt + 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
